// File: rtl/mem_pkg.sv
// Shared types and access-legality helpers for the data-memory responder.
package mem_pkg;

    typedef enum logic [2:0] {
        MODE_B  = 3'b000,
        MODE_H  = 3'b001,
        MODE_W  = 3'b010,
        MODE_BU = 3'b100,
        MODE_HU = 3'b101
    } addr_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } resp_state_e;

    function automatic logic mode_legal(input logic [2:0] mode);
        logic ok;
        case (mode)
            MODE_B, MODE_H, MODE_W, MODE_BU, MODE_HU: ok = 1'b1;
            default:                                  ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic misaligned(input logic [2:0] mode, input logic [1:0] lane);
        logic bad;
        case (mode)
            MODE_H, MODE_HU: bad = lane[0];
            MODE_W:          bad = (lane != 2'b00);
            default:         bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Unsigned modes only make sense for loads, so a store carrying one is rejected.
    function automatic logic access_err(input logic we, input logic [2:0] mode,
                                        input logic [1:0] lane);
        return !mode_legal(mode) || misaligned(mode, lane) || (we && mode[2]);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: load extraction/extension and store enable/replication.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  mode,
    input  logic [1:0]  lane,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wword
);
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte and halfword from the RAM word.
    always_comb begin
        byte_s = 8'h00;
        case (lane)
            2'd0:    byte_s = rword[7:0];
            2'd1:    byte_s = rword[15:8];
            2'd2:    byte_s = rword[23:16];
            2'd3:    byte_s = rword[31:24];
            default: byte_s = 8'h00;
        endcase
        if (lane[1]) begin
            half_s = rword[31:16];
        end else begin
            half_s = rword[15:0];
        end
    end

    // Extend load data and build store byte enables / lane-replicated write data.
    always_comb begin
        rdata = 32'h0000_0000;
        be    = 4'b0000;
        wword = wdata;
        case (mode)
            MODE_B: begin
                rdata = {{24{byte_s[7]}}, byte_s};
                be    = 4'b0001 << lane;
                wword = {4{wdata[7:0]}};
            end
            MODE_BU: begin
                rdata = {24'h00_0000, byte_s};
                be    = 4'b0001 << lane;
                wword = {4{wdata[7:0]}};
            end
            MODE_H: begin
                rdata = {{16{half_s[15]}}, half_s};
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wword = {2{wdata[15:0]}};
            end
            MODE_HU: begin
                rdata = {16'h0000, half_s};
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wword = {2{wdata[15:0]}};
            end
            MODE_W: begin
                rdata = rword;
                be    = 4'b1111;
                wword = wdata;
            end
            default: begin
                rdata = 32'h0000_0000;
                be    = 4'b0000;
                wword = wdata;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: one outstanding load/store, fixed wait
// states, internal byte-addressed little-endian RAM.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_ADDR_BITS = 17,
    parameter int LATENCY       = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [2:0]            req_mode,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);
    localparam int         WORD_BITS = MEM_ADDR_BITS - 2;
    localparam int         DEPTH     = 1 << WORD_BITS;
    localparam logic [3:0] LAT_LOAD  = 4'(LATENCY);
    localparam bit         ZERO_WAIT = (LATENCY == 0);

    resp_state_e           state_r;
    resp_state_e           state_next_s;
    logic [3:0]            cnt_r;
    logic                  lat_we_r;
    logic [ADDR_WIDTH-1:0] lat_addr_r;
    logic [2:0]            lat_mode_r;
    logic [DATA_WIDTH-1:0] lat_wdata_r;

    logic                  cur_we_s;
    logic [ADDR_WIDTH-1:0] cur_addr_s;
    logic [2:0]            cur_mode_s;
    logic [DATA_WIDTH-1:0] cur_wdata_s;
    logic                  accept_s;
    logic                  enter_resp_s;
    logic                  err_s;
    logic [WORD_BITS-1:0]  word_idx_s;
    logic [31:0]           rd_word_s;
    logic [31:0]           ld_data_s;
    logic [3:0]            be_s;
    logic [31:0]           st_word_s;

    logic [3:0][7:0]       ram_r [DEPTH];

    // With zero wait states the RAM is accessed on the accept edge itself, so
    // the access path must see the live request rather than the latched copy.
    always_comb begin
        if (state_r == ST_IDLE) begin
            cur_we_s    = req_we;
            cur_addr_s  = req_addr;
            cur_mode_s  = req_mode;
            cur_wdata_s = req_wdata;
        end else begin
            cur_we_s    = lat_we_r;
            cur_addr_s  = lat_addr_r;
            cur_mode_s  = lat_mode_r;
            cur_wdata_s = lat_wdata_r;
        end
    end

    // Request checks and RAM addressing for the active request.
    always_comb begin
        err_s      = ((cur_addr_s >> MEM_ADDR_BITS) != '0)
                     || access_err(cur_we_s, cur_mode_s, cur_addr_s[1:0]);
        word_idx_s = cur_addr_s[MEM_ADDR_BITS-1:2];
        rd_word_s  = ram_r[word_idx_s];
    end

    mem_lane_align u_align (
        .mode  (cur_mode_s),
        .lane  (cur_addr_s[1:0]),
        .rword (rd_word_s),
        .wdata (cur_wdata_s),
        .rdata (ld_data_s),
        .be    (be_s),
        .wword (st_word_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_next_s = ZERO_WAIT ? ST_RESP : ST_WAIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r <= 4'd1) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_RESP: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        req_ready    = (state_r == ST_IDLE) && rst;
        resp_valid   = (state_r == ST_RESP);
        accept_s     = req_valid && (state_r == ST_IDLE);
        enter_resp_s = (state_next_s == ST_RESP) && (state_r != ST_RESP);
    end

    // Request latch and wait counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r       <= 4'd0;
            lat_we_r    <= 1'b0;
            lat_addr_r  <= '0;
            lat_mode_r  <= 3'b000;
            lat_wdata_r <= '0;
        end else if (accept_s) begin
            cnt_r       <= LAT_LOAD;
            lat_we_r    <= req_we;
            lat_addr_r  <= req_addr;
            lat_mode_r  <= req_mode;
            lat_wdata_r <= req_wdata;
        end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Response data/error: captured entering RESP, cleared leaving it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (enter_resp_s) begin
            resp_err   <= err_s;
            resp_rdata <= (err_s || cur_we_s) ? '0 : ld_data_s;
        end else if (state_r == ST_RESP) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_rdata <= resp_rdata;
            resp_err   <= resp_err;
        end
    end

    // RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (rst && enter_resp_s && cur_we_s && !err_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    ram_r[word_idx_s][b] <= st_word_s[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: table-driven scoreboard on a LATENCY=2 instance plus
// hand sequences for reset-abort and LATENCY=0 back-to-back handshakes.
module tb_data_mem_responder;
    import mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_ready, req_we, resp_valid, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [2:0]  req_mode;
    logic        valid0, ready0, we0, rvalid0, err0;
    logic [31:0] addr0, wdata0, rdata0;
    logic [2:0]  mode0;

    data_mem_responder #(.LATENCY(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_mode(req_mode),
        .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    data_mem_responder #(.LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(valid0), .req_ready(ready0),
        .req_we(we0), .req_addr(addr0), .req_mode(mode0),
        .req_wdata(wdata0), .resp_valid(rvalid0),
        .resp_rdata(rdata0), .resp_err(err0)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  mode;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          edge_n;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        sb[$];
    vec_t        vecs[$];
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        no_push = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: push on handshake, pop and compare on response.
    always @(negedge clk) begin
        exp_t e;
        if (rst && req_valid && req_ready && !no_push) begin
            e.rdata  = exp_rdata;
            e.err    = exp_err;
            e.edge_n = cyc + 1;
            sb.push_back(e);
        end
        if (resp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                check("resp_latency", cyc - e.edge_n, 32'd2);
            end
        end
    end

    task automatic drive_tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_req(input vec_t v);
        bit got;
        drive_tick();
        req_we    = v.we;
        req_addr  = v.addr;
        req_mode  = v.mode;
        req_wdata = v.wdata;
        exp_rdata = v.rdata;
        exp_err   = v.err;
        req_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = req_ready;
        end
        if (!got) check("accept_timeout", 32'd0, 32'd1);
        drive_tick();
        req_valid = 1'b0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            check("resp_timeout", sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_mode = 3'b000; req_wdata = 32'd0;
        valid0 = 1'b0; we0 = 1'b0; addr0 = 32'd0; mode0 = 3'b000; wdata0 = 32'd0;
        exp_rdata = 32'd0; exp_err = 1'b0;

        //                we    addr           mode    wdata          rdata          err
        vecs.push_back('{1'b1, 32'h0000_0100, MODE_W,  32'hDEAD_BEEF, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0100, MODE_W,  32'h0,         32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0103, MODE_B,  32'h0,         32'hFFFF_FFDE, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0103, MODE_BU, 32'h0,         32'h0000_00DE, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0102, MODE_H,  32'h0,         32'hFFFF_DEAD, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0102, MODE_HU, 32'h0,         32'h0000_DEAD, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_0101, MODE_B,  32'hAAAA_AA11, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0100, MODE_W,  32'h0,         32'hDEAD_11EF, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0101, MODE_H,  32'h0,         32'h0000_0000, 1'b1});
        vecs.push_back('{1'b1, 32'h0000_0102, MODE_W,  32'h5555_5555, 32'h0000_0000, 1'b1});
        vecs.push_back('{1'b0, 32'h0000_0100, 3'b011,  32'h0,         32'h0000_0000, 1'b1});
        vecs.push_back('{1'b0, 32'h0000_0100, 3'b110,  32'h0,         32'h0000_0000, 1'b1});
        vecs.push_back('{1'b1, 32'h0000_0100, 3'b111,  32'h6666_6666, 32'h0000_0000, 1'b1});
        vecs.push_back('{1'b1, 32'h0000_0100, MODE_BU, 32'h7777_7777, 32'h0000_0000, 1'b1});
        vecs.push_back('{1'b1, 32'h0002_0000, MODE_W,  32'h8888_8888, 32'h0000_0000, 1'b1});
        vecs.push_back('{1'b0, 32'h0002_0000, MODE_W,  32'h0,         32'h0000_0000, 1'b1});
        vecs.push_back('{1'b0, 32'h0000_0100, MODE_W,  32'h0,         32'hDEAD_11EF, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0101, MODE_BU, 32'h0,         32'h0000_0011, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_0102, MODE_H,  32'h1234_CAFE, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0100, MODE_W,  32'h0,         32'hCAFE_11EF, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0100, MODE_B,  32'h0,         32'hFFFF_FFEF, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0100, MODE_H,  32'h0,         32'h0000_11EF, 1'b0});
        vecs.push_back('{1'b1, 32'h0001_FFFC, MODE_W,  32'h0BAD_F00D, 32'h0000_0000, 1'b0});
        vecs.push_back('{1'b0, 32'h0001_FFFC, MODE_W,  32'h0,         32'h0BAD_F00D, 1'b0});
        vecs.push_back('{1'b0, 32'h0001_FFFF, MODE_BU, 32'h0,         32'h0000_000B, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_0200, MODE_W,  32'hA5A5_A5A5, 32'h0000_0000, 1'b0});

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", {31'd0, resp_err}, 32'd0);
        check("rst_ready0", {31'd0, ready0}, 32'd0);
        drive_tick();
        rst = 1'b1;
        @(negedge clk);
        check("idle_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < vecs.size(); i++) do_req(vecs[i]);

        // Reset while a store waits: no response, no write.
        drive_tick();
        no_push   = 1'b1;
        req_we    = 1'b1; req_addr = 32'h0000_0200; req_mode = MODE_W; req_wdata = 32'h1234_5678;
        req_valid = 1'b1;
        @(negedge clk);
        check("abort_accept_ready", {31'd0, req_ready}, 32'd1);
        drive_tick();
        req_valid = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_ready_low", {31'd0, req_ready}, 32'd0);
            check("abort_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        drive_tick();
        rst = 1'b1;
        no_push = 1'b0;
        repeat (5) @(posedge clk);
        do_req('{1'b0, 32'h0000_0200, MODE_W, 32'h0, 32'hA5A5_A5A5, 1'b0});

        // LATENCY=0 with req_valid held high: accept every other cycle.
        drive_tick();
        we0 = 1'b1; addr0 = 32'h0000_0040; mode0 = MODE_W; wdata0 = 32'h0102_0304;
        valid0 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("b2b_resp_valid", {31'd0, rvalid0}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("b2b_ready", {31'd0, ready0}, (i % 2 == 0) ? 32'd0 : 32'd1);
            if (rvalid0) check("b2b_store_rdata", rdata0, 32'd0);
        end
        drive_tick();
        we0 = 1'b0; mode0 = MODE_HU; addr0 = 32'h0000_0042;
        @(negedge clk);
        check("b2b_load_ready", {31'd0, ready0}, 32'd1);
        @(negedge clk);
        check("b2b_load_valid", {31'd0, rvalid0}, 32'd1);
        check("b2b_load_rdata", rdata0, 32'h0000_0102);
        check("b2b_load_err", {31'd0, err0}, 32'd0);
        drive_tick();
        valid0 = 1'b0;
        @(negedge clk);
        check("b2b_idle_valid", {31'd0, rvalid0}, 32'd0);
        check("b2b_idle_rdata", rdata0, 32'd0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle responder for the pipeline's data-memory port: accepts one load/store request at a time over a valid/ready handshake, waits a fixed number of cycles, then returns read data or a store acknowledgement with an error flag. Sits between the MEM stage's load/store issue logic and a byte-addressed, little-endian RAM it owns internally. It replaces the zero-latency data memory when wait states are modelled. Access widths follow the RISC-V funct3 codes already carried through the pipeline as AddrMode.

## Interface
- ADDR_WIDTH, 32, width of request address
- DATA_WIDTH, 32, width of read/write data (fixed 32; other values unsupported)
- MEM_ADDR_BITS, 17, real address bits backed by RAM (2^17 bytes)
- LATENCY, 2, wait cycles between acceptance and response (0..15)
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept (high only in IDLE, low while rst=0)
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH  byte address
- req_mode  in  3  000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned
- req_wdata  in  DATA_WIDTH  store data, low-order bytes used for byte/half
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, out-of-range or illegal mode; valid with resp_valid

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1; on req_valid&req_ready latch we/addr/mode/wdata, load counter with LATENCY; go WAIT if LATENCY>0, else RESP.
- WAIT: counter decrements each cycle; at count 1 -> RESP. Input changes ignored.
- RESP: resp_valid=1 for exactly this cycle; next state IDLE unconditionally.
- Error check (on latched request): addr >= 2^MEM_ADDR_BITS; half with addr[0]=1; word with addr[1:0]!=0; mode 011/110/111; store with mode[2]=1. Error -> resp_err=1, resp_rdata=0, no RAM write.
- Loads: byte lane = addr[1:0]; 000/001 sign-extend, 100/101 zero-extend, 010 full word.
- Stores: write only the addressed 1/2/4 bytes; other bytes unchanged.
- RAM read and write both occur at the edge entering RESP; resp_rdata/resp_err registered at that edge, cleared to 0 at the edge leaving RESP.
- A load following a store to the same address returns the stored data.

## Timing
- Accept at edge E0 -> resp_valid high in the cycle after edge E0+LATENCY (LATENCY+1 cycles after accept).
- Throughput: one request per LATENCY+2 cycles; req_ready low from E0 until the edge leaving RESP.
- Reset (rst=0 at an edge): state IDLE, resp_valid=0, resp_rdata=0, resp_err=0, counter 0; RAM contents retained.
- Reset mid-operation: pending request dropped, no response; store not performed unless its write edge already passed.
- req_valid held high through RESP: next request accepted the cycle after RESP (in IDLE), never in RESP.

## Structure
- Package mem_pkg: addr_mode_e enum (MODE_B, MODE_H, MODE_W, MODE_BU, MODE_HU), resp_state_e enum, mode-legality function.
- Sub-module mem_lane_align (combinational): load extraction/extension and store byte-enable/merge generation; top holds FSM, counter, request register, RAM.

## Test plan
- LATENCY=2: store word 0xDEADBEEF @0x100, then load word @0x100 -> each resp_valid 3 cycles after accept, rdata 0xDEADBEEF, err 0.
- After above: load byte @0x103 -> 0xFFFFFFDE; byte-unsigned @0x103 -> 0x000000DE; half @0x102 -> 0xFFFFDEAD; half-unsigned -> 0x0000DEAD.
- Store byte 0x11 @0x101 then load word @0x100 -> 0xDEAD11EF.
- Half load @0x101, word store @0x102, mode 011, address 0x00020000 -> resp_err=1, rdata 0, RAM word @0x100 unchanged.
- LATENCY=0 back-to-back with req_valid held high -> accept every 2 cycles, resp_valid exactly one cycle each, req_ready low in RESP.
- rst=0 while in WAIT of a store 0x12345678 @0x200 -> no resp_valid, req_ready 0 during reset, later load @0x200 returns prior contents.
